// File: rtl/bus_uart_tx_if.sv
// CPU bus slice seen by bus_uart_tx: chip select, strobes, word address and data.
interface bus_uart_tx_if;
  logic        cs;
  logic [1:0]  address;
  logic        read;
  logic        write;
  logic [31:0] data_in;
  logic [3:0]  data_strobes;
  logic [31:0] data_out;

  modport master (output cs, address, read, write, data_in, data_strobes, input data_out);
  modport slave  (input cs, address, read, write, data_in, data_strobes, output data_out);
endinterface

// File: rtl/bus_uart_tx.sv
// Memory-mapped 8N1 UART transmitter with TX FIFO, status and baud-divisor registers.
// Optional macro BUS_UART_TX_IRQ_EN adds the irq output and the R/W STATUS[4] irq enable.
module bus_uart_tx #(
  parameter int unsigned  FIFO_DEPTH      = 16,
  parameter logic [15:0]  DEFAULT_DIVISOR = 16'd433
) (
  input  logic           clock,
  input  logic           reset,
  bus_uart_tx_if.slave   bus,
  output logic           tx
`ifdef BUS_UART_TX_IRQ_EN
  ,
  output logic           irq
`endif
);

  localparam int unsigned   AW         = $clog2(FIFO_DEPTH);
  localparam logic [AW:0]   FULL_COUNT = (AW+1)'(FIFO_DEPTH);

  typedef enum logic [1:0] {S_IDLE, S_START, S_DATA, S_STOP} state_t;

  state_t        state;
  logic [7:0]    mem [FIFO_DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic [AW:0]   count;
  logic [15:0]   divisor;
  logic [15:0]   bit_cnt;
  logic [2:0]    bit_idx;
  logic [7:0]    shifter;
  logic          overflow;
  logic          irq_en;

  logic          wr_en, rd_en, push_req, push, pop;
  logic          empty, full, busy, bit_end;
  logic [31:0]   read_word;
  logic          unused_bits;

  assign unused_bits = ^{bus.data_in[31:16], bus.data_strobes[3:2]};

  always_comb begin
    wr_en    = bus.cs & bus.write;
    rd_en    = bus.cs & bus.read;
    push_req = wr_en & (bus.address == 2'd0) & bus.data_strobes[0];
    empty    = (count == '0);
    full     = (count == FULL_COUNT);
    push     = push_req & ~full;
    busy     = (state != S_IDLE);
    bit_end  = (bit_cnt == '0);
    // A new byte is taken either from idle or straight out of the stop bit.
    pop      = ~empty & ((state == S_IDLE) | ((state == S_STOP) & bit_end));
  end

  always_comb begin
    read_word = '0;
    case (bus.address)
      2'd1:    read_word = {27'b0, irq_en, overflow, busy, full, empty};
      2'd2:    read_word = {16'b0, divisor};
      default: read_word = '0;
    endcase
  end

  always_ff @(posedge clock) begin
    if (push) mem[wr_ptr] <= bus.data_in[7:0];
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      bus.data_out <= '0;
      divisor      <= DEFAULT_DIVISOR;
      overflow     <= 1'b0;
    end else begin
      bus.data_out <= rd_en ? read_word : '0;
      if (wr_en && bus.address == 2'd2) begin
        if (bus.data_strobes[0]) divisor[7:0]  <= bus.data_in[7:0];
        if (bus.data_strobes[1]) divisor[15:8] <= bus.data_in[15:8];
      end
      if (push_req && full)
        overflow <= 1'b1;
      else if (wr_en && bus.address == 2'd1 && bus.data_strobes[0] && bus.data_in[3])
        overflow <= 1'b0;
    end
  end

`ifdef BUS_UART_TX_IRQ_EN
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      irq_en <= 1'b0;
      irq    <= 1'b0;
    end else begin
      if (wr_en && bus.address == 2'd1 && bus.data_strobes[0]) irq_en <= bus.data_in[4];
      irq <= irq_en & empty & ~busy;
    end
  end
`else
  assign irq_en = 1'b0;
`endif

  // tx is registered: each branch drives the level of the bit being entered.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state   <= S_IDLE;
      tx      <= 1'b1;
      bit_cnt <= '0;
      bit_idx <= '0;
      shifter <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          tx <= 1'b1;
          if (!empty) begin
            shifter <= mem[rd_ptr];
            bit_cnt <= divisor;
            tx      <= 1'b0;
            state   <= S_START;
          end
        end
        S_START: begin
          if (bit_end) begin
            bit_cnt <= divisor;
            bit_idx <= '0;
            tx      <= shifter[0];
            state   <= S_DATA;
          end else begin
            bit_cnt <= bit_cnt - 16'd1;
          end
        end
        S_DATA: begin
          if (bit_end) begin
            bit_cnt <= divisor;
            if (bit_idx == 3'd7) begin
              tx    <= 1'b1;
              state <= S_STOP;
            end else begin
              bit_idx <= bit_idx + 3'd1;
              tx      <= shifter[1];
              shifter <= {1'b0, shifter[7:1]};
            end
          end else begin
            bit_cnt <= bit_cnt - 16'd1;
          end
        end
        S_STOP: begin
          if (bit_end) begin
            if (!empty) begin
              shifter <= mem[rd_ptr];
              bit_cnt <= divisor;
              tx      <= 1'b0;
              state   <= S_START;
            end else begin
              tx    <= 1'b1;
              state <= S_IDLE;
            end
          end else begin
            bit_cnt <= bit_cnt - 16'd1;
          end
        end
        default: begin
          tx    <= 1'b1;
          state <= S_IDLE;
        end
      endcase
    end
  end

endmodule
